// File: rtl/vx_wfa_pkg.sv
// Shared definitions for the weighted fair arbiter family.
// Holds the effective-weight helper, age constants (used with VX_WFA_AGING_EN) and the index-width helper.
package vx_wfa_pkg;

  localparam int AGE_W = 8;
  localparam logic [AGE_W-1:0] AGE_MAX = 8'd255;

  // Index width for a requester count; a single requester still gets a 1-bit index.
  function automatic int wfa_log2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero weight behaves as weight 1 so that requester is never starved.
  function automatic int wfa_eff_weight(input int w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/vx_rr_pick.sv
// Combinational round-robin picker: first set bit of requests searching upward
// from start_ptr with wrap-around. Shared by the arbiter family.
module vx_rr_pick
  import vx_wfa_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int LOG_NUM_REQS = wfa_log2(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0]     requests,
  input  logic [LOG_NUM_REQS-1:0] start_ptr,
  output logic [LOG_NUM_REQS-1:0] grant_index,
  output logic [NUM_REQS-1:0]     grant_onehot,
  output logic                    grant_valid
);

  always_comb begin : p_pick
    int idx;
    logic [LOG_NUM_REQS-1:0] sel;
    grant_index  = '0;
    grant_onehot = '0;
    grant_valid  = 1'b0;
    idx          = 0;
    sel          = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      // Explicit wrap keeps non-power-of-2 requester counts in range.
      idx = int'(start_ptr) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      sel = LOG_NUM_REQS'(idx);
      if (!grant_valid && requests[sel]) begin
        grant_valid       = 1'b1;
        grant_index       = sel;
        grant_onehot[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_weighted_fair_arbiter.sv
// Weighted round-robin arbiter: each requester receives up to its weight in grants per round.
// Optional starvation aging is enabled with the VX_WFA_AGING_EN macro.
module vx_weighted_fair_arbiter
  import vx_wfa_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int WEIGHT_W     = 4,
  parameter int LOCK_ENABLE  = 0,
  parameter int LOG_NUM_REQS = wfa_log2(NUM_REQS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_REQS-1:0]          requests,
  input  logic [NUM_REQS*WEIGHT_W-1:0] weights,
  output logic [LOG_NUM_REQS-1:0]      grant_index,
  output logic [NUM_REQS-1:0]          grant_onehot,
  output logic                         grant_valid
);

  if (NUM_REQS == 1) begin : g_single

    logic unused_ok;
    assign unused_ok    = ^{clk, reset, enable, weights};
    assign grant_onehot = requests;
    assign grant_valid  = requests[0];
    assign grant_index  = '0;

  end else begin : g_multi

    typedef logic [WEIGHT_W-1:0] weight_t;

    weight_t                 credit      [NUM_REQS];
    weight_t                 credit_base [NUM_REQS];
    weight_t                 credit_next [NUM_REQS];
    weight_t                 eff_w       [NUM_REQS];
    logic [LOG_NUM_REQS-1:0] rr_ptr;
    logic [LOG_NUM_REQS-1:0] ptr_next;
    logic [NUM_REQS-1:0]     eligible;
    logic [NUM_REQS-1:0]     arb_vec;
    logic                    refill;
    logic                    advance;
    logic [LOG_NUM_REQS-1:0] rr_index;
    logic [NUM_REQS-1:0]     rr_onehot;
    logic                    rr_valid_unused;
    logic [LOG_NUM_REQS-1:0] sel_index;
    logic [NUM_REQS-1:0]     sel_onehot;

    always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
        eff_w[i]    = WEIGHT_W'(wfa_eff_weight(int'(weights[i*WEIGHT_W +: WEIGHT_W])));
        eligible[i] = requests[i] && (credit[i] != '0);
      end
    end

    // When every active requester has spent its credit, this cycle already arbitrates the new round.
    assign refill  = (eligible == '0) && (requests != '0);
    assign arb_vec = refill ? requests : eligible;

    vx_rr_pick #(
      .NUM_REQS     (NUM_REQS),
      .LOG_NUM_REQS (LOG_NUM_REQS)
    ) u_rr_pick (
      .requests     (arb_vec),
      .start_ptr    (rr_ptr),
      .grant_index  (rr_index),
      .grant_onehot (rr_onehot),
      .grant_valid  (rr_valid_unused)
    );

`ifdef VX_WFA_AGING_EN
    logic [AGE_W-1:0]        age [NUM_REQS];
    logic                    aged_any;
    logic [LOG_NUM_REQS-1:0] aged_index;

    // Lowest-index requester that has waited the full age limit overrides the weighted pick.
    always_comb begin
      aged_any   = 1'b0;
      aged_index = '0;
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (requests[i] && (age[i] == AGE_MAX)) begin
          aged_any   = 1'b1;
          aged_index = LOG_NUM_REQS'(i);
        end
      end
    end

    assign sel_index  = aged_any ? aged_index : rr_index;
    assign sel_onehot = aged_any ? (NUM_REQS'(1) << aged_index) : rr_onehot;

    always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (reset) begin
          age[i] <= '0;
        end else if (advance && (sel_index == LOG_NUM_REQS'(i))) begin
          age[i] <= '0;
        end else if (requests[i] && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + AGE_W'(1);
        end
      end
    end
`else
    assign sel_index  = rr_index;
    assign sel_onehot = rr_onehot;
`endif

    assign grant_valid  = |requests;
    assign grant_index  = sel_index;
    assign grant_onehot = grant_valid ? sel_onehot : '0;
    assign advance      = grant_valid && ((LOCK_ENABLE == 0) || enable);

    always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
        credit_base[i] = refill ? eff_w[i] : credit[i];
        credit_next[i] = credit_base[i];
        if ((sel_index == LOG_NUM_REQS'(i)) && (credit_base[i] != '0)) begin
          credit_next[i] = credit_base[i] - WEIGHT_W'(1);
        end
      end
      ptr_next = (sel_index == LOG_NUM_REQS'(NUM_REQS - 1)) ? '0 : sel_index + LOG_NUM_REQS'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < NUM_REQS; i++) credit[i] <= '0;
        rr_ptr <= '0;
      end else if (advance) begin
        for (int i = 0; i < NUM_REQS; i++) credit[i] <= credit_next[i];
        rr_ptr <= ptr_next;
      end
    end

  end

endmodule

// File: tb/tb_vx_weighted_fair_arbiter.sv
// Scoreboard bench for vx_weighted_fair_arbiter: a 4-requester locked instance and a 3-requester free-running one.
// Expected grants come from a credit/round model; models aging too when VX_WFA_AGING_EN is defined.
module tb_vx_weighted_fair_arbiter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  requests_a;
  logic [15:0] weights_a;
  logic [1:0]  grant_index_a;
  logic [3:0]  grant_onehot_a;
  logic        grant_valid_a;
  logic [2:0]  requests_b;
  logic [11:0] weights_b;
  logic [1:0]  grant_index_b;
  logic [2:0]  grant_onehot_b;
  logic        grant_valid_b;

  vx_weighted_fair_arbiter #(
    .NUM_REQS    (4),
    .WEIGHT_W    (4),
    .LOCK_ENABLE (1)
  ) dut_a (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .requests     (requests_a),
    .weights      (weights_a),
    .grant_index  (grant_index_a),
    .grant_onehot (grant_onehot_a),
    .grant_valid  (grant_valid_a)
  );

  vx_weighted_fair_arbiter #(
    .NUM_REQS    (3),
    .WEIGHT_W    (4),
    .LOCK_ENABLE (0)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .requests     (requests_b),
    .weights      (weights_b),
    .grant_index  (grant_index_b),
    .grant_onehot (grant_onehot_b),
    .grant_valid  (grant_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] idx_a;
    logic [3:0] oh_a;
    logic       v_a;
    logic [1:0] idx_b;
    logic [2:0] oh_b;
    logic       v_b;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: remaining grants per requester in the current round and the next search start.
  int m_cr  [2][4];
  int m_ptr [2];
`ifdef VX_WFA_AGING_EN
  int m_age [2][4];
`endif

  function automatic void model(input int d, input int n, input logic [3:0] req,
                                input logic [15:0] wv, input bit adv_en, input bit rst,
                                output int g, output bit v);
    int w[4];
    bit elig;
    bit refill;
    bit adv;
    int ga;
    int base;
    v    = 1'b0;
    elig = 1'b0;
    g    = -1;
    ga   = -1;
    for (int i = 0; i < 4; i++) w[i] = 1;
    for (int i = 0; i < n; i++) begin
      w[i] = (wv[i*4 +: 4] == 4'd0) ? 1 : int'(wv[i*4 +: 4]);
      if (req[i]) v = 1'b1;
      if (req[i] && m_cr[d][i] > 0) elig = 1'b1;
    end
    refill = v && !elig;
    for (int k = 0; k < n; k++) begin
      int i;
      i = (m_ptr[d] + k) % n;
      if (g < 0 && req[i] && (refill || m_cr[d][i] > 0)) g = i;
    end
`ifdef VX_WFA_AGING_EN
    for (int i = n - 1; i >= 0; i--) if (req[i] && m_age[d][i] == 255) ga = i;
    if (ga >= 0) g = ga;
`endif
    if (!v) g = 0;
    adv = v && adv_en;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_cr[d][i] = 0;
`ifdef VX_WFA_AGING_EN
        m_age[d][i] = 0;
`endif
      end
      m_ptr[d] = 0;
    end else begin
`ifdef VX_WFA_AGING_EN
      for (int i = 0; i < n; i++) begin
        if (adv && i == g) m_age[d][i] = 0;
        else if (req[i] && m_age[d][i] < 255) m_age[d][i] = m_age[d][i] + 1;
      end
`endif
      if (adv) begin
        for (int i = 0; i < n; i++) begin
          base = refill ? w[i] : m_cr[d][i];
          if (i == g && base > 0) base = base - 1;
          m_cr[d][i] = base;
        end
        m_ptr[d] = (g + 1) % n;
      end
    end
  endfunction

  task automatic step(input logic [3:0] ra, input logic [15:0] wa, input logic en_i,
                      input logic rst_i, input logic [2:0] rb, input logic [11:0] wb);
    exp_t e;
    int   g;
    bit   v;
    @(posedge clk);
    #1;
    requests_a = ra;
    weights_a  = wa;
    enable     = en_i;
    reset      = rst_i;
    requests_b = rb;
    weights_b  = wb;
    model(0, 4, ra, wa, en_i, rst_i, g, v);
    e.v_a   = v;
    e.idx_a = 2'(g);
    e.oh_a  = v ? 4'(1 << g) : 4'd0;
    model(1, 3, {1'b0, rb}, {4'h0, wb}, 1'b1, rst_i, g, v);
    e.v_b   = v;
    e.idx_b = 2'(g);
    e.oh_b  = v ? 3'(1 << g) : 3'd0;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUTs present mid-cycle against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("a.valid",  32'(grant_valid_a),  32'(e.v_a));
        check("a.index",  32'(grant_index_a),  32'(e.idx_a));
        check("a.onehot", 32'(grant_onehot_a), 32'(e.oh_a));
        check("b.valid",  32'(grant_valid_b),  32'(e.v_b));
        check("b.index",  32'(grant_index_b),  32'(e.idx_b));
        check("b.onehot", 32'(grant_onehot_b), 32'(e.oh_b));
      end
    end
  end

  initial begin
    logic [15:0] wa_r;
    logic [11:0] wb_r;
    reset      = 1'b1;
    enable     = 1'b0;
    requests_a = '0;
    weights_a  = '0;
    requests_b = '0;
    weights_b  = '0;
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0;
      for (int i = 0; i < 4; i++) begin
        m_cr[d][i] = 0;
`ifdef VX_WFA_AGING_EN
        m_age[d][i] = 0;
`endif
      end
    end

    repeat (2) step(4'b0000, 16'h1111, 1'b0, 1'b1, 3'b000, 12'h111);

    // Equal weights: plain rotation.
    repeat (8) step(4'b1111, 16'h1111, 1'b1, 1'b0, 3'b111, 12'h111);

    // Requester 3 (a) / 2 (b) weighted 3.
    step(4'b1111, 16'h3111, 1'b1, 1'b1, 3'b111, 12'h311);
    repeat (13) step(4'b1111, 16'h3111, 1'b1, 1'b0, 3'b111, 12'h311);

    // Locked grant holds while enable is low.
    repeat (3) step(4'b0110, 16'h1111, 1'b0, 1'b0, 3'b110, 12'h111);
    repeat (3) step(4'b0110, 16'h1111, 1'b1, 1'b0, 3'b110, 12'h111);

    // Zero weight on a lone requester refills every cycle.
    repeat (4) step(4'b0100, 16'h1011, 1'b1, 1'b0, 3'b100, 12'h011);

    // Reset in the middle of a round.
    repeat (2) step(4'b1111, 16'h2222, 1'b1, 1'b0, 3'b111, 12'h222);
    step(4'b1111, 16'h2222, 1'b1, 1'b1, 3'b111, 12'h222);
    repeat (4) step(4'b1111, 16'h2222, 1'b1, 1'b0, 3'b111, 12'h222);

    // Long stall with heavy weight on requester 0.
    repeat (258) step(4'b0011, 16'h111F, 1'b0, 1'b0, 3'b011, 12'h11F);
    repeat (20) step(4'b0011, 16'h111F, 1'b1, 1'b0, 3'b011, 12'h11F);

    // Random traffic, weights changing occasionally and rare resets.
    wa_r = 16'h1111;
    wb_r = 12'h111;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        wa_r = 16'($urandom);
        wb_r = 12'($urandom);
      end
      step(4'($urandom), wa_r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0),
           3'($urandom), wb_r);
    end

    step(4'b0000, 16'h1111, 1'b0, 1'b0, 3'b000, 12'h111);
    repeat (3) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
